// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IF_IDLE,
        IF_RUN
    } if_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect from execute, decode handoff.
interface instr_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, instr, pc, misaligned,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, instr, pc, misaligned,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; DEPTH must be a power of two.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  fetch_entry_t               i_data,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset && !i_flush && w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order response buffering,
// redirect flush with discard of wrong-path responses.
//   state   | meaning
//   IF_IDLE | first cycle after reset release, no request issued
//   IF_RUN  | issuing requests as credit allows, accepting responses
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic                i_clk,
    input logic                i_reset,
    instr_fetch_unit_if.master io_bus
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    if_state_t        r_state;
    if_state_t        w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_rsp_pc;
    logic [31:0]      r_pc_last;
    logic [31:0]      w_redir_pc;
    logic [31:0]      w_pc_out;
    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] r_discard;
    logic [OUT_W-1:0] w_kept;
    logic [OUT_W-1:0] w_out_next;
    logic [CNT_W-1:0] w_count;
    logic             r_misaligned;
    logic             w_credit;
    logic             w_req_valid;
    logic             w_fire;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_empty;
    logic             w_full;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;

    // Credit covers every accepted request that will land in the buffer.
    assign w_kept     = r_outstanding - r_discard;
    assign w_credit   = (r_outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                        ((32'(w_count) + 32'(w_kept)) < 32'(FIFO_DEPTH));
    assign w_fire     = w_req_valid && io_bus.imem_req_ready;
    assign w_rsp      = io_bus.imem_rsp_valid;
    assign w_flush    = io_bus.redirect_valid;
    assign w_redir_pc = {io_bus.redirect_pc[31:2], 2'b00};
    assign w_out_next = r_outstanding + OUT_W'(w_fire) - OUT_W'(w_rsp);
    assign w_push     = w_rsp && (r_discard == '0) && !w_flush;
    assign w_pop      = !w_empty && io_bus.if_ready;
    assign w_push_entry = '{pc: r_rsp_pc, instr: io_bus.imem_rsp_data};
    assign w_pc_out   = w_empty ? r_pc_last : w_head.pc;

    assign io_bus.imem_req_valid = w_req_valid;
    assign io_bus.imem_req_addr  = r_fetch_pc;
    assign io_bus.if_valid       = !w_empty;
    assign io_bus.instr          = w_empty ? NOP_INSTR : w_head.instr;
    assign io_bus.pc             = w_pc_out;
    assign io_bus.misaligned     = r_misaligned;

    instr_fetch_unit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        case (r_state)
            IF_IDLE: w_state_next = IF_RUN;
            IF_RUN:  w_req_valid  = w_credit;
            default: w_state_next = IF_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= IF_IDLE;
            // rsp_pc follows fetch_pc so the first response is tagged with its own address.
            r_fetch_pc    <= io_bus.redirect_valid ? w_redir_pc : RESET_PC;
            r_rsp_pc      <= io_bus.redirect_valid ? w_redir_pc : RESET_PC;
            r_pc_last     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            r_pc_last     <= w_pc_out;
            if (io_bus.redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                if (r_state == IF_RUN) begin
                    r_discard <= w_out_next;
                    if (io_bus.redirect_pc[1:0] != 2'b00) r_misaligned <= 1'b1;
                end
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_rsp) begin
                    if (r_discard != '0) r_discard <= r_discard - OUT_W'(1);
                    else                 r_rsp_pc  <= r_rsp_pc + 32'd4;
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset) !(w_push && w_full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written redirect/reset sequences.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus_if();

    instr_fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus_if)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ifr;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    pend_t       pend_q[$];
    vec_t        tv[12];
    int          cyc;
    int          mem_delay;
    int          n_vec;
    int          n_err;
    logic        s_req_valid, s_if_valid, s_mis, s_fire, s_rsp, s_rst;
    logic [31:0] s_addr, s_pc, s_instr;
    logic        sb_en;
    logic [31:0] sb_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[21:0], 10'b0};
    endfunction

    task automatic check(input string name, input logic [98:0] got, input logic [98:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: sample at negedge, then advance the imem model just after the posedge.
    task automatic cycle();
        @(negedge clk);
        s_req_valid = bus_if.imem_req_valid;
        s_addr      = bus_if.imem_req_addr;
        s_if_valid  = bus_if.if_valid;
        s_pc        = bus_if.pc;
        s_instr     = bus_if.instr;
        s_mis       = bus_if.misaligned;
        s_fire      = bus_if.imem_req_valid & bus_if.imem_req_ready;
        s_rsp       = bus_if.imem_rsp_valid;
        s_rst       = rst_n;
        if (sb_en && rst_n && !bus_if.redirect_valid && bus_if.if_valid && bus_if.if_ready) begin
            check("sb_pc", bus_if.pc, sb_pc);
            check("sb_instr", bus_if.instr, mem_word(sb_pc));
            sb_pc += 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!s_rst) begin
            pend_q.delete();
        end else begin
            if (s_rsp && pend_q.size() > 0) void'(pend_q.pop_front());
            if (s_fire === 1'b1) pend_q.push_back('{addr: s_addr, due: cyc - 1 + mem_delay});
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus_if.imem_rsp_valid = 1'b1;
            bus_if.imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            bus_if.imem_rsp_valid = 1'b0;
            bus_if.imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.if_ready       = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        sb_en = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_if_valid(input int budget);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!s_if_valid && k < budget);
        check("if_valid_wait", s_if_valid, 1'b1);
    endtask

    task automatic run_until_pc(input logic [31:0] target, input int budget);
        int k = 0;
        while (sb_pc != target && k < budget) begin
            cycle();
            k++;
        end
        check("pc_progress", sb_pc, target);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        mem_delay = 1;
        sb_en = 1'b0;
        sb_pc = 32'h0;
        rst_n = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.if_ready       = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = 32'h0;

        // Zero-wait start-up, then imem stalls for 3 cycles with 0x8 pending.
        tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, NOP_INSTR};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, NOP_INSTR};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, NOP_INSTR};
        tv[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, NOP_INSTR};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, mem_word(32'h00)};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04, mem_word(32'h04)};
        tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h04, NOP_INSTR};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h04, NOP_INSTR};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h04, NOP_INSTR};
        tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, mem_word(32'h08)};
        tv[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, mem_word(32'h0C)};
        tv[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10, mem_word(32'h10)};

        cycle();
        cycle();
        for (int i = 0; i < 12; i++) begin
            rst_n                 = tv[i].rst;
            bus_if.imem_req_ready = tv[i].rdy;
            bus_if.if_ready       = tv[i].ifr;
            cycle();
            check($sformatf("vec%0d", i),
                  {s_req_valid, s_addr, s_if_valid, s_pc, s_instr, s_mis},
                  {tv[i].e_rv, tv[i].e_addr, tv[i].e_iv, tv[i].e_pc, tv[i].e_instr, 1'b0});
        end

        // Decode stall: head holds, requests stop once the buffer is committed.
        do_reset();
        bus_if.if_ready = 1'b0;
        wait_if_valid(10);
        check("stall_pc", s_pc, 32'h0);
        check("stall_instr", s_instr, mem_word(32'h0));
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("stall_valid", s_if_valid, 1'b1);
            check("stall_pc", s_pc, 32'h0);
            check("stall_instr", s_instr, mem_word(32'h0));
        end
        check("stall_req_drop", s_req_valid, 1'b0);
        bus_if.if_ready = 1'b1;
        sb_en = 1'b1;
        sb_pc = 32'h0;
        run_until_pc(32'h18, 30);
        sb_en = 1'b0;

        // Redirect with two requests in flight and slow imem.
        do_reset();
        mem_delay = 3;
        cycle();
        cycle();
        cycle();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h100;
        cycle();
        check("redir_no_credit", s_req_valid, 1'b0);
        bus_if.redirect_valid = 1'b0;
        sb_en = 1'b1;
        sb_pc = 32'h100;
        cycle();
        check("redir_flush", s_if_valid, 1'b0);
        check("redir_addr", s_addr, 32'h100);
        run_until_pc(32'h108, 40);

        // Misaligned redirect followed immediately by a second redirect.
        sb_en = 1'b0;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h102;
        cycle();
        bus_if.redirect_pc    = 32'h200;
        cycle();
        check("mis_set", s_mis, 1'b1);
        check("mis_addr", s_addr, 32'h100);
        check("mis_flush", s_if_valid, 1'b0);
        bus_if.redirect_valid = 1'b0;
        sb_en = 1'b1;
        sb_pc = 32'h200;
        cycle();
        check("mis_sticky", s_mis, 1'b1);
        check("b2b_addr", s_addr, 32'h200);
        run_until_pc(32'h20C, 40);
        sb_en = 1'b0;

        // Redirect together with a response and a pop, then reset mid-stream.
        do_reset();
        mem_delay = 1;
        for (int k = 0; k < 5; k++) cycle();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h42;
        cycle();
        check("coinc_pop", s_if_valid, 1'b1);
        bus_if.redirect_valid = 1'b0;
        sb_en = 1'b1;
        sb_pc = 32'h40;
        cycle();
        check("coinc_flush", s_if_valid, 1'b0);
        check("coinc_mis", s_mis, 1'b1);
        run_until_pc(32'h48, 20);
        sb_en = 1'b0;
        rst_n = 1'b0;
        cycle();
        cycle();
        check("rst_outputs",
              {s_req_valid, s_addr, s_if_valid, s_pc, s_instr, s_mis},
              {1'b0, 32'h0, 1'b0, 32'h0, NOP_INSTR, 1'b0});
        rst_n = 1'b1;
        sb_en = 1'b1;
        sb_pc = 32'h0;
        run_until_pc(32'h8, 20);
        sb_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
